// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// The state encoding is visible on the debug state port, so it is fixed at 3 bits.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    WAIT_MEM = 3'd2,
    STALL    = 3'd3,
    HALTED   = 3'd4
  } fetch_state_e;

  localparam int BOOT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/fetch_controller_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: drives the PC register enable/mux and the IF/ID flush,
// holding redirects that arrive while the PC cannot move.
//
// Handshake: a redirect is "applied" in exactly the cycle pc_select=1; the PC
// register loads new_pc on that rising edge and the IF/ID word is flushed.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             stall_req,
  input  logic             imem_ready,
  input  logic             halt,
  output logic             pc_enable,
  output logic             pc_select,
  output logic [WIDTH-1:0] new_pc,
  output logic             flush,
  output logic             if_valid,
  output logic [2:0]       state,
  output logic [7:0]       redirect_count
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fetch_state_e     state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             redirect;
  logic [WIDTH-1:0] redirect_tgt;

  // A live branch is always newer than anything held in the pending register.
  assign redirect_tgt = branch_taken ? branch_target : pend_tgt_q;
  assign state        = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    redirect   = 1'b0;
    pc_enable  = 1'b0;
    pc_select  = 1'b0;
    new_pc     = '0;
    flush      = 1'b0;
    if_valid   = 1'b0;

    case (state_q)
      BOOT: begin
        flush = 1'b1;
        if (branch_taken) begin
          pend_d     = 1'b1;
          pend_tgt_d = branch_target;
        end
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
        else                         boot_cnt_d = boot_cnt_q + 4'd1;
      end
      RUN: begin
        if (branch_taken || pend_q) begin
          redirect = 1'b1;
        end else if (stall_req) begin
          state_d = STALL;
        end else if (!imem_ready) begin
          state_d = WAIT_MEM;
        end else if (halt) begin
          if_valid = 1'b1;
          state_d  = HALTED;
        end else begin
          pc_enable = 1'b1;
          if_valid  = 1'b1;
        end
      end
      STALL: begin
        if (branch_taken) begin
          redirect = 1'b1;
          state_d  = RUN;
        end else if (!stall_req) begin
          state_d = RUN;
        end
      end
      WAIT_MEM: begin
        // The held redirect is released in the first cycle memory is ready.
        if (imem_ready) begin
          state_d  = RUN;
          redirect = branch_taken || pend_q;
        end else if (branch_taken) begin
          pend_d     = 1'b1;
          pend_tgt_d = branch_target;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (redirect) begin
      pc_enable = 1'b1;
      pc_select = 1'b1;
      new_pc    = redirect_tgt;
      flush     = 1'b1;
      if_valid  = 1'b0;
      pend_d    = 1'b0;
    end
  end

  sat_counter #(.WIDTH(8)) u_redirect_cnt (
    .clock (clock),
    .reset (reset),
    .en    (redirect),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Scenario bench for fetch_controller: per-cycle expected outputs go through a
// scoreboard queue; the redirect counter is tracked by a saturating model.
module tb_fetch_controller;
  import fetch_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = '0;
  logic       stall_req = 1'b0;
  logic       imem_ready = 1'b1;
  logic       halt = 1'b0;
  logic       pc_enable, pc_select, flush, if_valid;
  logic [7:0] new_pc;
  logic [2:0] state;
  logic [7:0] redirect_count;

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [14:0] exp_q[$];

  // {stall, ready, halt, branch, target, expected outputs}
  typedef struct packed {
    logic        st;
    logic        rdy;
    logic        hl;
    logic        bt;
    logic [7:0]  tg;
    logic [14:0] exp;
  } step_t;

  fetch_controller #(.WIDTH(8), .BOOT_CYCLES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall_req      (stall_req),
    .imem_ready     (imem_ready),
    .halt           (halt),
    .pc_enable      (pc_enable),
    .pc_select      (pc_select),
    .new_pc         (new_pc),
    .flush          (flush),
    .if_valid       (if_valid),
    .state          (state),
    .redirect_count (redirect_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [14:0] obs;
  assign obs = {pc_enable, pc_select, new_pc, flush, if_valid, state};

  // ---------------- expected-value builders ----------------
  function automatic logic [14:0] ev(logic pe, logic ps, logic [7:0] np, logic fl,
                                     logic iv, fetch_state_e st);
    return {pe, ps, np, fl, iv, 3'(st)};
  endfunction

  function automatic logic [14:0] e_norm();
    return ev(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, RUN);
  endfunction

  function automatic logic [14:0] e_redir(logic [7:0] t, fetch_state_e st);
    return ev(1'b1, 1'b1, t, 1'b1, 1'b0, st);
  endfunction

  function automatic logic [14:0] e_hold(fetch_state_e st);
    return ev(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, st);
  endfunction

  function automatic logic [14:0] e_boot();
    return ev(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, BOOT);
  endfunction

  function automatic step_t mk(logic st, logic rdy, logic hl, logic bt,
                               logic [7:0] tg, logic [14:0] e);
    step_t s;
    s.st = st; s.rdy = rdy; s.hl = hl; s.bt = bt; s.tg = tg; s.exp = e;
    return s;
  endfunction

  function automatic logic [7:0] sat_inc(logic [7:0] c);
    return (c == 8'd255) ? 8'd255 : c + 8'd1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(logic st, logic rdy, logic hl, logic bt, logic [7:0] tg);
    stall_req     = st;
    imem_ready    = rdy;
    halt          = hl;
    branch_taken  = bt;
    branch_target = tg;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [14:0] want;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
      exp_q.push_back(e_boot());
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== 8'd0) begin
        bad++;
        $display("FAIL reset[%0d] redirect_count: got %0d want 0", i, redirect_count);
      end
      @(posedge clock); #1;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
  endtask

  task automatic test_boot();
    step_t s[$];
    logic [14:0] want;
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_boot()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_boot()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_norm()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_norm()));
    foreach (s[i]) begin
      drive(s[i].st, s[i].rdy, s[i].hl, s[i].bt, s[i].tg);
      exp_q.push_back(s[i].exp);
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL boot[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL boot[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_redirect();
    step_t s[$];
    logic [14:0] want;
    s.push_back(mk(0, 1, 0, 1, 8'h3C, e_redir(8'h3C, RUN)));
    s.push_back(mk(0, 1, 0, 0, 8'h3C, e_norm()));
    s.push_back(mk(0, 1, 0, 1, 8'hA5, e_redir(8'hA5, RUN)));
    s.push_back(mk(0, 1, 0, 1, 8'h01, e_redir(8'h01, RUN)));
    s.push_back(mk(0, 1, 0, 0, 8'hFF, e_norm()));
    foreach (s[i]) begin
      drive(s[i].st, s[i].rdy, s[i].hl, s[i].bt, s[i].tg);
      exp_q.push_back(s[i].exp);
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL redirect[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL redirect[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_wait_mem();
    step_t s[$];
    logic [14:0] want;
    s.push_back(mk(0, 0, 0, 0, 8'h00, e_hold(RUN)));
    s.push_back(mk(0, 0, 0, 1, 8'h10, e_hold(WAIT_MEM)));
    s.push_back(mk(0, 0, 0, 0, 8'h77, e_hold(WAIT_MEM)));
    s.push_back(mk(0, 1, 0, 0, 8'h77, e_redir(8'h10, WAIT_MEM)));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_norm()));
    foreach (s[i]) begin
      drive(s[i].st, s[i].rdy, s[i].hl, s[i].bt, s[i].tg);
      exp_q.push_back(s[i].exp);
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL wait_mem[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL wait_mem[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stall();
    step_t s[$];
    logic [14:0] want;
    s.push_back(mk(1, 1, 0, 1, 8'h22, e_redir(8'h22, RUN)));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_norm()));
    s.push_back(mk(1, 1, 0, 0, 8'h00, e_hold(RUN)));
    s.push_back(mk(1, 1, 0, 0, 8'h00, e_hold(STALL)));
    s.push_back(mk(1, 1, 0, 1, 8'h5A, e_redir(8'h5A, STALL)));
    s.push_back(mk(1, 0, 1, 0, 8'h00, e_hold(RUN)));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_hold(STALL)));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_norm()));
    foreach (s[i]) begin
      drive(s[i].st, s[i].rdy, s[i].hl, s[i].bt, s[i].tg);
      exp_q.push_back(s[i].exp);
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL stall[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL stall[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_halt();
    step_t s[$];
    logic [14:0] want;
    s.push_back(mk(0, 0, 1, 0, 8'h00, e_hold(RUN)));
    s.push_back(mk(0, 1, 1, 0, 8'h00, e_hold(WAIT_MEM)));
    s.push_back(mk(0, 1, 1, 0, 8'h00, ev(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, RUN)));
    s.push_back(mk(0, 1, 0, 1, 8'h44, e_hold(HALTED)));
    s.push_back(mk(1, 0, 1, 1, 8'h45, e_hold(HALTED)));
    foreach (s[i]) begin
      drive(s[i].st, s[i].rdy, s[i].hl, s[i].bt, s[i].tg);
      exp_q.push_back(s[i].exp);
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL halt[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL halt[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end

    // Reset pulse leaves HALTED; a branch during BOOT is held and applied first.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    exp_cnt = 8'd0;
    exp_q.push_back(e_boot());
    @(negedge clock);
    want = exp_q.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL halt_reset outputs: got %h want %h", obs, want);
    end
    total++;
    if (redirect_count !== exp_cnt) begin
      bad++;
      $display("FAIL halt_reset redirect_count: got %0d want %0d", redirect_count, exp_cnt);
    end
    @(posedge clock); #1;
    reset = 1'b1;

    s.delete();
    s.push_back(mk(0, 1, 0, 1, 8'h66, e_boot()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_boot()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_redir(8'h66, RUN)));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_norm()));
    foreach (s[i]) begin
      drive(s[i].st, s[i].rdy, s[i].hl, s[i].bt, s[i].tg);
      exp_q.push_back(s[i].exp);
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL halt_reboot[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL halt_reboot[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    step_t s[$];
    logic [14:0] want;
    s.push_back(mk(0, 0, 0, 0, 8'h00, e_hold(RUN)));
    s.push_back(mk(0, 0, 0, 1, 8'h99, e_hold(WAIT_MEM)));
    s.push_back(mk(0, 0, 0, 0, 8'h00, e_boot()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_boot()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_boot()));
    s.push_back(mk(0, 1, 0, 0, 8'h00, e_norm()));
    foreach (s[i]) begin
      drive(s[i].st, s[i].rdy, s[i].hl, s[i].bt, s[i].tg);
      // Step 2 is taken with reset held low; the held redirect must vanish.
      if (i == 2) begin
        reset = 1'b0;
        branch_taken = 1'b1;
        exp_cnt = 8'd0;
      end
      if (i == 3) reset = 1'b1;
      exp_q.push_back(s[i].exp);
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_mid_wait[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL reset_mid_wait[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_saturate();
    logic [14:0] want;
    logic [7:0]  tg;
    for (int i = 0; i < 301; i++) begin
      tg = 8'($urandom_range(0, 255));
      if (i < 300) begin
        drive(1'b0, 1'b1, 1'b0, 1'b1, tg);
        exp_q.push_back(e_redir(tg, RUN));
      end else begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, tg);
        exp_q.push_back(e_norm());
      end
      @(negedge clock);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL saturate[%0d] outputs: got %h want %h", i, obs, want);
      end
      total++;
      if (redirect_count !== exp_cnt) begin
        bad++;
        $display("FAIL saturate[%0d] redirect_count: got %0d want %0d", i, redirect_count, exp_cnt);
      end
      if (want[13]) exp_cnt = sat_inc(exp_cnt);
      @(posedge clock); #1;
    end
    total++;
    if (redirect_count !== 8'd255) begin
      bad++;
      $display("FAIL saturate_final redirect_count: got %0d want 255", redirect_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_boot();
    test_redirect();
    test_wait_mem();
    test_stall();
    test_halt();
    test_reset_mid_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
